imem_encoder: RTL and testbench
===============================

# imem_encoder

Streaming LEGv8 instruction encoder and instruction-memory loader: accepts field-level instruction descriptions over a valid/ready handshake, packs each into a 32-bit machine word for the supported subset (ADDI, ADDS, SUBS, B, B.LT, BL, BR, CBZ, LDUR, STUR), and emits {byte address, word} pairs to the instruction-memory write port. It is the producer side of the opcode fields the control unit decodes. Testbenches and boot logic use it to load programs without hand-assembled hex.

## Interface
- ADDR_W, 64, width of instruction byte address
- clk  in  1  clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse, begins a load session; ignored unless IDLE
- base_addr  in  ADDR_W  first byte address, sampled on start
- in_valid / in_ready  in / out  1  input handshake
- in_op  in  4  0 ADDI, 1 ADDS, 2 SUBS, 3 B, 4 B.LT, 5 BL, 6 BR, 7 CBZ, 8 LDUR, 9 STUR, 10-15 illegal
- in_rd, in_rn, in_rm  in  5 each  Rd/Rt, Rn, Rm
- in_imm  in  26  two's-complement immediate/offset (words for branches)
- in_last  in  1  marks final item of session
- out_valid / out_ready  out / in  1  memory-write handshake
- out_addr  out  ADDR_W  byte address of word
- out_instr  out  32  encoded word
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at session end
- err_sticky  out  1  any rejected item this session
- word_count  out  16  words emitted this session, saturates at 0xFFFF
- err_count  out  8  items rejected this session, saturates at 0xFF

## Operation
- FSM: IDLE -> (start) LOAD -> (accepted item with in_last) DRAIN -> (out_valid==0 or final word handshaken) DONE -> IDLE. DONE lasts exactly one cycle, done=1 there.
- On start: addr counter <= base_addr; word_count, err_count, err_sticky cleared.
- in_ready = (state==LOAD) && (!out_valid || out_ready). Item accepted when in_valid && in_ready.
- Encodings (fields in_rd->[4:0] unless stated):
  - ADDI: 0x244<<22 | imm12<<10 | rn<<5 | rd; imm must be 0..4095 (zero-extended).
  - ADDS: 0x558<<21 | rm<<16 | rn<<5 | rd; SUBS: 0x758<<21, same fields; shamt=0.
  - B: 0x05<<26 | imm26; BL: 0x25<<26 | imm26; always in range.
  - B.LT: 0x54<<24 | imm19<<5 | 0x0B; CBZ: 0xB4<<24 | imm19<<5 | rd; imm must satisfy -262144..262143 (in_imm[25:18] all equal to in_imm[18]).
  - BR: 0xD61F0000 | rn<<5.
  - LDUR: 0x7C2<<21 | imm9<<12 | rn<<5 | rd; STUR: 0x7C0<<21, same; imm -256..255; bits [11:10]=00.
  - Unused register inputs ignored.
- Rejected item (illegal op or immediate out of range): consumed, no word emitted, address not advanced, err_count++, err_sticky=1. Rejected in_last still moves to DRAIN.
- Emitted word: out_addr=current counter, counter += 4 (wraps modulo 2^ADDR_W), word_count++.
- start while busy: ignored.

## Timing
- Reset (async, any state, mid-session included): state IDLE; in_ready, out_valid, busy, done, err_sticky = 0; out_addr, out_instr, word_count, err_count = 0; addr counter = 0. Partially loaded session is abandoned.
- Latency 1: item accepted at edge N gives out_valid=1 with word after edge N.
- Throughput 1 word/cycle with out_ready held high.
- out_valid high with out_ready low: out_addr/out_instr held stable, in_ready=0.
- Simultaneous out handshake and new accept in same cycle: register reloads, no bubble.
- Rejected item with out_valid held: no new output; pending word unaffected.
- start first accepted cycle: LOAD entered after start edge; in_ready may rise the cycle after start.

## Test plan
- Reset mid-session with out_valid=1 -> all outputs 0 immediately (no clock), busy=0; fresh start works.
- start base 0x0, ADDI rd=1 rn=31 imm=5, then SUBS rd=3 rn=1 rm=2 last -> words 0x910017E1 @0x0, 0xEB020023 @0x4; done pulse; word_count=2.
- B imm=-1, B.LT imm=-2, BL imm=3, BR rn=30 -> 0x17FFFFFF, 0x54FFFFCB, 0x94000003, 0xD61F03C0 at consecutive addresses.
- LDUR rd=0 rn=1 imm=8 -> 0xF8408020; STUR imm=256 and in_op=12 -> both rejected, err_count=2, err_sticky=1, next word address unchanged.
- base 0x100, out_ready low 3 cycles during stream -> out_instr held, in_ready=0, no item lost/duplicated; addresses 0x100, 0x104, 0x108.
- start pulsed while busy -> ignored; base_addr=2^64-4, two words -> addresses 0xFFFF_FFFF_FFFF_FFFC then 0x0.

Source files
------------

// File: rtl/imem_encoder_if.sv
// Handshake bundle between an instruction source and the imem_encoder:
// the field-level item stream in, and the {address, word} memory-write stream out.
interface imem_encoder_if #(
  parameter int ADDR_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [4:0]        in_rm;
  logic [25:0]       in_imm;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_instr;

  modport master (
    output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last, out_ready,
    input  in_ready, out_valid, out_addr, out_instr
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last, out_ready,
    output in_ready, out_valid, out_addr, out_instr
  );
endinterface

// File: rtl/imem_encoder.sv
// Streaming LEGv8 encoder: packs field-level instruction items into 32-bit words
// and emits them with consecutive byte addresses to an instruction-memory write port.
module imem_encoder #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  imem_encoder_if.slave     bus,
  output logic              busy,
  output logic              done,
  output logic              err_sticky,
  output logic [15:0]       word_count,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_ADDI = 4'd0,
    OP_ADDS = 4'd1,
    OP_SUBS = 4'd2,
    OP_B    = 4'd3,
    OP_BLT  = 4'd4,
    OP_BL   = 4'd5,
    OP_BR   = 4'd6,
    OP_CBZ  = 4'd7,
    OP_LDUR = 4'd8,
    OP_STUR = 4'd9
  } op_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [31:0]       out_instr_q;

  logic              accept;
  logic              legal;
  logic [31:0]       enc;
  logic              fits_imm12;
  logic              fits_imm19;
  logic              fits_imm9;

  assign bus.in_ready  = (state == LOAD) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_instr = out_instr_q;
  assign busy          = (state != IDLE);

  assign accept = bus.in_valid && bus.in_ready;

  // Range checks on the signed 26-bit immediate: upper bits must be a pure sign extension.
  assign fits_imm12 = (bus.in_imm[25:12] == 14'd0);
  assign fits_imm19 = (&bus.in_imm[25:18]) || (~|bus.in_imm[25:18]);
  assign fits_imm9  = (&bus.in_imm[25:8]) || (~|bus.in_imm[25:8]);

  always_comb begin
    legal = 1'b0;
    enc   = 32'd0;
    case (bus.in_op)
      OP_ADDI: begin
        legal = fits_imm12;
        enc   = {10'h244, bus.in_imm[11:0], bus.in_rn, bus.in_rd};
      end
      OP_ADDS: begin
        legal = 1'b1;
        enc   = {11'h558, bus.in_rm, 6'd0, bus.in_rn, bus.in_rd};
      end
      OP_SUBS: begin
        legal = 1'b1;
        enc   = {11'h758, bus.in_rm, 6'd0, bus.in_rn, bus.in_rd};
      end
      OP_B: begin
        legal = 1'b1;
        enc   = {6'h05, bus.in_imm};
      end
      OP_BLT: begin
        legal = fits_imm19;
        enc   = {8'h54, bus.in_imm[18:0], 5'h0B};
      end
      OP_BL: begin
        legal = 1'b1;
        enc   = {6'h25, bus.in_imm};
      end
      OP_BR: begin
        legal = 1'b1;
        enc   = 32'hD61F_0000 | {22'd0, bus.in_rn, 5'd0};
      end
      OP_CBZ: begin
        legal = fits_imm19;
        enc   = {8'hB4, bus.in_imm[18:0], bus.in_rd};
      end
      OP_LDUR: begin
        legal = fits_imm9;
        enc   = {11'h7C2, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
      end
      OP_STUR: begin
        legal = fits_imm9;
        enc   = {11'h7C0, bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rd};
      end
      default: begin
        legal = 1'b0;
        enc   = 32'd0;
      end
    endcase
  end

  // A consumed output frees the register; a legal accept in the same cycle refills it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_instr_q <= 32'd0;
      done        <= 1'b0;
      err_sticky  <= 1'b0;
      word_count  <= 16'd0;
      err_count   <= 8'd0;
    end else begin
      done <= 1'b0;
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            addr_q     <= base_addr;
            word_count <= 16'd0;
            err_count  <= 8'd0;
            err_sticky <= 1'b0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            if (legal) begin
              out_valid_q <= 1'b1;
              out_addr_q  <= addr_q;
              out_instr_q <= enc;
              addr_q      <= addr_q + ADDR_W'(4);
              if (word_count != 16'hFFFF) begin
                word_count <= word_count + 16'd1;
              end
            end else begin
              err_sticky <= 1'b1;
              if (err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
              end
            end
            if (bus.in_last) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!out_valid_q || bus.out_ready) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_encoder.sv
// Self-checking bench for imem_encoder: table vectors, hand-built stall/wrap/reset
// sequences and a randomized session scored against an arithmetic reference encoder.
module tb_imem_encoder;

  localparam int ADDR_W = 64;
  localparam longint K10 = 1024;
  localparam longint K12 = 4096;
  localparam longint K16 = 65536;
  localparam longint K21 = 2097152;
  localparam longint K22 = 4194304;
  localparam longint K24 = 16777216;
  localparam longint K26 = 67108864;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy;
  logic              done;
  logic              err_sticky;
  logic [15:0]       word_count;
  logic [7:0]        err_count;

  imem_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  imem_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .bus        (bus.slave),
    .busy       (busy),
    .done       (done),
    .err_sticky (err_sticky),
    .word_count (word_count),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
  } exp_t;

  typedef struct {
    logic [3:0]        op;
    logic [4:0]        rd;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [25:0]       imm;
    bit                last;
    logic [ADDR_W-1:0] base;
    bit                legal;
    logic [31:0]       word;
  } vec_t;

  exp_t              sbq[$];
  vec_t              tbl[15];
  int                checks = 0;
  int                failures = 0;
  logic [ADDR_W-1:0] model_addr = '0;
  int                model_words = 0;
  int                model_errs = 0;
  int                ready_mode = 0;

  function automatic longint wrap_mod(input longint v, input longint m);
    return ((v % m) + m) % m;
  endfunction

  // Reference encoder: immediates treated as signed integers, fields placed by weight.
  function automatic void ref_encode(input int op, input int rd, input int rn, input int rm,
                                     input logic [25:0] imm, output bit legal,
                                     output logic [31:0] word);
    longint s;
    longint acc;
    s = longint'(imm);
    if (imm[25]) s = s - K26;
    legal = 1'b1;
    acc = 0;
    case (op)
      0: begin legal = (s >= 0 && s <= 4095); acc = 'h244 * K22 + s * K10 + rn * 32 + rd; end
      1: acc = 'h558 * K21 + rm * K16 + rn * 32 + rd;
      2: acc = 'h758 * K21 + rm * K16 + rn * 32 + rd;
      3: acc = 5 * K26 + wrap_mod(s, K26);
      4: begin legal = (s >= -262144 && s <= 262143); acc = 'h54 * K24 + wrap_mod(s, 524288) * 32 + 11; end
      5: acc = 'h25 * K26 + wrap_mod(s, K26);
      6: acc = 'hD61F0000 + rn * 32;
      7: begin legal = (s >= -262144 && s <= 262143); acc = 'hB4 * K24 + wrap_mod(s, 524288) * 32 + rd; end
      8: begin legal = (s >= -256 && s <= 255); acc = 'h7C2 * K21 + wrap_mod(s, 512) * K12 + rn * 32 + rd; end
      9: begin legal = (s >= -256 && s <= 255); acc = 'h7C0 * K21 + wrap_mod(s, 512) * K12 + rn * 32 + rd; end
      default: legal = 1'b0;
    endcase
    word = acc[31:0];
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // out_ready is owned by this process; mode 0 = high, 1 = low, 2 = random.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.out_ready = 1'b0;
        2:       bus.out_ready = ($urandom_range(0, 2) != 0);
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_word: got addr 0x%0h instr 0x%0h, expected none",
                 bus.out_addr, bus.out_instr);
      end else begin
        e = sbq.pop_front();
        check_output("out_addr", bus.out_addr, e.addr);
        check_output("out_instr", 64'(bus.out_instr), 64'(e.word));
      end
    end
  end

  task automatic start_session(input logic [ADDR_W-1:0] base);
    base_addr = base;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_addr = base;
    model_words = 0;
    model_errs = 0;
  endtask

  task automatic apply_stimulus(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                                input logic [4:0] rm, input logic [25:0] imm, input bit last,
                                input bit exp_legal, input logic [31:0] exp_word);
    bit accepted;
    int n;
    exp_t e;
    bus.in_op = op;
    bus.in_rd = rd;
    bus.in_rn = rn;
    bus.in_rm = rm;
    bus.in_imm = imm;
    bus.in_last = last;
    bus.in_valid = 1'b1;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        if (exp_legal) begin
          e.addr = model_addr;
          e.word = exp_word;
          sbq.push_back(e);
          model_addr = model_addr + 64'd4;
          model_words++;
        end else begin
          model_errs++;
        end
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 200 cycles, expected an accept");
    end
  endtask

  task automatic send_model(input int op, input int rd, input int rn, input int rm,
                            input logic [25:0] imm, input bit last);
    bit lg;
    logic [31:0] w;
    ref_encode(op, rd, rn, rm, imm, lg, w);
    apply_stimulus(4'(op), 5'(rd), 5'(rn), 5'(rm), imm, last, lg, w);
  endtask

  task automatic finish_session();
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    while (!got && n < 400) begin
      @(negedge clk);
      if (done) got = 1'b1;
      n++;
    end
    check_output("done_seen", 64'(got), 64'd1);
    check_output("busy_in_done", 64'(busy), 64'd1);
    check_output("word_count", 64'(word_count), 64'(model_words));
    check_output("err_count", 64'(err_count), 64'(model_errs));
    check_output("err_sticky", 64'(err_sticky), 64'(model_errs != 0));
    check_output("pending_words", 64'(sbq.size()), 64'd0);
    @(negedge clk);
    check_output("done_one_cycle", 64'(done), 64'd0);
    check_output("busy_after_done", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check_output({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_output({tag, "_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_done"}, 64'(done), 64'd0);
    check_output({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
    check_output({tag, "_out_addr"}, bus.out_addr, 64'd0);
    check_output({tag, "_out_instr"}, 64'(bus.out_instr), 64'd0);
    check_output({tag, "_word_count"}, 64'(word_count), 64'd0);
    check_output({tag, "_err_count"}, 64'(err_count), 64'd0);
  endtask

  initial begin
    logic [25:0] imm;
    int op;
    bit lg;
    logic [31:0] w;

    bus.in_valid = 1'b0;
    bus.in_op = 4'd0;
    bus.in_rd = 5'd0;
    bus.in_rn = 5'd0;
    bus.in_rm = 5'd0;
    bus.in_imm = 26'd0;
    bus.in_last = 1'b0;

    //           op     rd     rn     rm     imm            last  base      legal word
    tbl[0]  = '{4'd0, 5'd1, 5'd31, 5'd0, 26'd5,         1'b0, 64'h0,  1'b1, 32'h910017E1};
    tbl[1]  = '{4'd2, 5'd3, 5'd1,  5'd2, 26'd0,         1'b1, 64'h0,  1'b1, 32'hEB020023};
    tbl[2]  = '{4'd3, 5'd0, 5'd0,  5'd0, 26'h3FFFFFF,   1'b0, 64'h40, 1'b1, 32'h17FFFFFF};
    tbl[3]  = '{4'd4, 5'd0, 5'd0,  5'd0, 26'h3FFFFFE,   1'b0, 64'h40, 1'b1, 32'h54FFFFCB};
    tbl[4]  = '{4'd5, 5'd0, 5'd0,  5'd0, 26'd3,         1'b0, 64'h40, 1'b1, 32'h94000003};
    tbl[5]  = '{4'd6, 5'd7, 5'd30, 5'd9, 26'd0,         1'b0, 64'h40, 1'b1, 32'hD61F03C0};
    tbl[6]  = '{4'd8, 5'd0, 5'd1,  5'd0, 26'd8,         1'b0, 64'h40, 1'b1, 32'hF8408020};
    tbl[7]  = '{4'd9, 5'd0, 5'd1,  5'd0, 26'd256,       1'b0, 64'h40, 1'b0, 32'h0};
    tbl[8]  = '{4'd12, 5'd0, 5'd1, 5'd0, 26'd0,         1'b0, 64'h40, 1'b0, 32'h0};
    tbl[9]  = '{4'd0, 5'd1, 5'd2,  5'd0, 26'd4096,      1'b0, 64'h40, 1'b0, 32'h0};
    tbl[10] = '{4'd7, 5'd1, 5'd0,  5'd0, 26'h0040000,   1'b0, 64'h40, 1'b0, 32'h0};
    tbl[11] = '{4'd7, 5'd7, 5'd0,  5'd0, 26'd4,         1'b0, 64'h40, 1'b1, 32'hB4000087};
    tbl[12] = '{4'd8, 5'd3, 5'd2,  5'd0, 26'h3FFFF00,   1'b0, 64'h40, 1'b1, 32'hF8500043};
    tbl[13] = '{4'd9, 5'd5, 5'd6,  5'd0, 26'd255,       1'b0, 64'h40, 1'b1, 32'hF80FF0C5};
    tbl[14] = '{4'd1, 5'd4, 5'd5,  5'd6, 26'd0,         1'b1, 64'h40, 1'b1, 32'hAB0600A4};

    #3 reset_n = 1'b0;
    #9;
    check_all_zero("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] table vectors");
    for (int i = 0; i < 15; i++) begin
      if (i == 0 || tbl[i-1].last) start_session(tbl[i].base);
      apply_stimulus(tbl[i].op, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].imm, tbl[i].last,
                     tbl[i].legal, tbl[i].word);
      if (tbl[i].last) finish_session();
    end

    $display("[TB] output stall");
    start_session(64'h100);
    ready_mode = 1;
    ref_encode(0, 2, 3, 0, 26'd7, lg, w);
    apply_stimulus(4'd0, 5'd2, 5'd3, 5'd0, 26'd7, 1'b0, lg, w);
    bus.in_op = 4'd1;
    bus.in_rd = 5'd4;
    bus.in_rn = 5'd5;
    bus.in_rm = 5'd6;
    bus.in_imm = 26'd0;
    bus.in_last = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check_output("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check_output("stall_out_addr", bus.out_addr, 64'h100);
      check_output("stall_out_instr", 64'(bus.out_instr), 64'h91001C62);
      @(posedge clk);
      #1;
    end
    ready_mode = 0;
    send_model(1, 4, 5, 6, 26'd0, 1'b0);
    send_model(2, 8, 9, 10, 26'd0, 1'b1);
    finish_session();

    $display("[TB] address wrap and start while busy");
    start_session(64'hFFFF_FFFF_FFFF_FFFC);
    send_model(3, 0, 0, 0, 26'd10, 1'b0);
    base_addr = 64'h500;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    send_model(5, 0, 0, 0, 26'h3FFFFFB, 1'b1);
    finish_session();

    $display("[TB] randomized session");
    ready_mode = 2;
    start_session({$urandom, $urandom} & ~64'h3);
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      case ($urandom_range(0, 4))
        0: imm = 26'($urandom_range(0, 4095));
        1: imm = 26'(-int'($urandom_range(1, 300)));
        2: imm = 26'($urandom_range(250, 300));
        3: imm = ($urandom_range(0, 1) != 0) ? 26'h0040000 : 26'h3FC0000;
        default: imm = 26'($urandom);
      endcase
      send_model(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), imm, i == 79);
    end
    finish_session();
    ready_mode = 0;

    $display("[TB] reset mid-session");
    start_session(64'h2000);
    send_model(13, 0, 0, 0, 26'd0, 1'b0);
    ready_mode = 1;
    send_model(0, 1, 2, 0, 26'd9, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sbq.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;
    start_session(64'h10);
    send_model(0, 1, 1, 0, 26'd1, 1'b1);
    finish_session();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
